// File: rtl/hex2seg_decoder.sv
// Registered 4-bit to two-digit decimal 7-segment decoder.
// Shows i_hex (0..15) as "00".."15" with one clock of latency. Segment bit
// order is {g,f,e,d,c,b,a}. Polarity and leading-zero blanking are set by parameters.
module hex2seg_decoder #(
    parameter bit ACTIVE_LOW         = 1'b1,
    parameter bit BLANK_LEADING_ZERO = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg_1,
    output logic [6:0] o_seg_0
);

    // All segments off, for the selected polarity.
    localparam logic [6:0] SEG_BLANK = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

    // Decimal digit to active-high segment pattern {g,f,e,d,c,b,a}.
    // Out-of-range codes cannot occur and map to all-off.
    function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b0111111;
            4'd1:    pattern = 7'b0000110;
            4'd2:    pattern = 7'b1011011;
            4'd3:    pattern = 7'b1001111;
            4'd4:    pattern = 7'b1100110;
            4'd5:    pattern = 7'b1101101;
            4'd6:    pattern = 7'b1111101;
            4'd7:    pattern = 7'b0000111;
            4'd8:    pattern = 7'b1111111;
            4'd9:    pattern = 7'b1101111;
            default: pattern = 7'b0000000;
        endcase
        return pattern;
    endfunction

    // Convert an active-high pattern to the driven polarity.
    function automatic logic [6:0] apply_polarity(input logic [6:0] pattern);
        logic [6:0] driven;
        if (ACTIVE_LOW) begin
            driven = ~pattern;
        end else begin
            driven = pattern;
        end
        return driven;
    endfunction

    logic       tens_s;
    logic [3:0] ones_s;
    logic [6:0] seg_1_d;
    logic [6:0] seg_0_d;
    logic [6:0] seg_1_q;
    logic [6:0] seg_0_q;

    // Split the value into tens/ones and encode both digits.
    always_comb begin
        tens_s  = 1'b0;
        ones_s  = i_hex;
        seg_1_d = SEG_BLANK;
        seg_0_d = SEG_BLANK;

        if (i_hex >= 4'd10) begin
            tens_s = 1'b1;
            ones_s = i_hex - 4'd10;
        end else begin
            tens_s = 1'b0;
            ones_s = i_hex;
        end

        if (BLANK_LEADING_ZERO && !tens_s) begin
            seg_1_d = SEG_BLANK;
        end else begin
            seg_1_d = apply_polarity(digit_to_seg({3'b000, tens_s}));
        end

        seg_0_d = apply_polarity(digit_to_seg(ones_s));
    end

    // Output registers. Reset blanks both digits on the same edge and overrides i_hex.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            seg_1_q <= SEG_BLANK;
            seg_0_q <= SEG_BLANK;
        end else begin
            seg_1_q <= seg_1_d;
            seg_0_q <= seg_0_d;
        end
    end

    assign o_seg_1 = seg_1_q;
    assign o_seg_0 = seg_0_q;

endmodule

// File: tb/tb_hex2seg_decoder.sv
// Directed, table-driven bench for hex2seg_decoder. It runs three instances
// on shared inputs: the defaults, leading-zero blanking, and active-high outputs.
module tb_hex2seg_decoder;

    logic       clk;
    logic       rst;
    logic [3:0] hex;
    logic [6:0] def_seg_1, def_seg_0;
    logic [6:0] blz_seg_1, blz_seg_0;
    logic [6:0] ah_seg_1,  ah_seg_0;

    int n_total;
    int n_pass;

    hex2seg_decoder dut_def (
        .i_clk(clk), .i_rst(rst), .i_hex(hex),
        .o_seg_1(def_seg_1), .o_seg_0(def_seg_0)
    );

    hex2seg_decoder #(.ACTIVE_LOW(1'b1), .BLANK_LEADING_ZERO(1'b1)) dut_blz (
        .i_clk(clk), .i_rst(rst), .i_hex(hex),
        .o_seg_1(blz_seg_1), .o_seg_0(blz_seg_0)
    );

    hex2seg_decoder #(.ACTIVE_LOW(1'b0), .BLANK_LEADING_ZERO(1'b0)) dut_ah (
        .i_clk(clk), .i_rst(rst), .i_hex(hex),
        .o_seg_1(ah_seg_1), .o_seg_0(ah_seg_0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] hex;
        logic [6:0] seg_1;   // expected, active-low encoding
        logic [6:0] seg_0;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Go to the next rising edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;

        // Down-count from 15 to 0, then wrap to 15. Expected values are active low.
        vecs[0]  = '{4'd15, 7'b1111001, 7'b0010010};
        vecs[1]  = '{4'd14, 7'b1111001, 7'b0011001};
        vecs[2]  = '{4'd13, 7'b1111001, 7'b0110000};
        vecs[3]  = '{4'd12, 7'b1111001, 7'b0100100};
        vecs[4]  = '{4'd11, 7'b1111001, 7'b1111001};
        vecs[5]  = '{4'd10, 7'b1111001, 7'b1000000};
        vecs[6]  = '{4'd9,  7'b1000000, 7'b0010000};
        vecs[7]  = '{4'd8,  7'b1000000, 7'b0000000};
        vecs[8]  = '{4'd7,  7'b1000000, 7'b1111000};
        vecs[9]  = '{4'd6,  7'b1000000, 7'b0000010};
        vecs[10] = '{4'd5,  7'b1000000, 7'b0010010};
        vecs[11] = '{4'd4,  7'b1000000, 7'b0011001};
        vecs[12] = '{4'd3,  7'b1000000, 7'b0110000};
        vecs[13] = '{4'd2,  7'b1000000, 7'b0100100};
        vecs[14] = '{4'd1,  7'b1000000, 7'b1111001};
        vecs[15] = '{4'd0,  7'b1000000, 7'b1000000};
        vecs[16] = '{4'd15, 7'b1111001, 7'b0010010};

        // Reset held for two cycles while i_hex = 7.
        rst = 1'b1;
        hex = 4'd7;
        tick();
        tick();
        check("reset_def_seg1", def_seg_1, 7'b1111111);
        check("reset_def_seg0", def_seg_0, 7'b1111111);
        check("reset_blz_seg1", blz_seg_1, 7'b1111111);
        check("reset_ah_seg1",  ah_seg_1,  7'b0000000);
        check("reset_ah_seg0",  ah_seg_0,  7'b0000000);

        // Release reset with 15 applied. That edge must load the first value.
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            hex = vecs[i].hex;
            #1;
            // The output keeps the previous value until the next edge.
            if (i == 0) begin
                check("pre_edge_blank_seg1", def_seg_1, 7'b1111111);
                check("pre_edge_blank_seg0", def_seg_0, 7'b1111111);
            end else begin
                check($sformatf("hold_seg1_%0d", i), def_seg_1, vecs[i-1].seg_1);
                check($sformatf("hold_seg0_%0d", i), def_seg_0, vecs[i-1].seg_0);
            end
            tick();
            check($sformatf("dn_seg1_hex%0d", vecs[i].hex), def_seg_1, vecs[i].seg_1);
            check($sformatf("dn_seg0_hex%0d", vecs[i].hex), def_seg_0, vecs[i].seg_0);
            check($sformatf("blz_seg1_hex%0d", vecs[i].hex), blz_seg_1,
                  (vecs[i].hex < 4'd10) ? 7'b1111111 : vecs[i].seg_1);
            check($sformatf("blz_seg0_hex%0d", vecs[i].hex), blz_seg_0, vecs[i].seg_0);
            check($sformatf("ah_seg0_hex%0d", vecs[i].hex), ah_seg_0, ~vecs[i].seg_0);
        end

        // Latency: step 3 -> 8. "03" stays until the edge that samples 8.
        hex = 4'd3;
        tick();
        check("lat_03_seg1", def_seg_1, 7'b1000000);
        check("lat_03_seg0", def_seg_0, 7'b0110000);
        hex = 4'd8;
        #1;
        check("lat_hold_seg0", def_seg_0, 7'b0110000);
        tick();
        check("lat_08_seg1", def_seg_1, 7'b1000000);
        check("lat_08_seg0", def_seg_0, 7'b0000000);
        check("ah_08_seg1",  ah_seg_1,  7'b0111111);
        check("ah_08_seg0",  ah_seg_0,  7'b1111111);

        // Mid-run reset while i_hex = 12: blank for one cycle, then "12".
        hex = 4'd12;
        rst = 1'b1;
        tick();
        check("mid_rst_seg1", def_seg_1, 7'b1111111);
        check("mid_rst_seg0", def_seg_0, 7'b1111111);
        check("mid_rst_ah_seg1", ah_seg_1, 7'b0000000);
        rst = 1'b0;
        tick();
        check("mid_12_seg1", def_seg_1, 7'b1111001);
        check("mid_12_seg0", def_seg_0, 7'b0100100);

        // Leading-zero blanking, values 5 and 11.
        hex = 4'd5;
        tick();
        check("blz_5_seg1",  blz_seg_1, 7'b1111111);
        check("blz_5_seg0",  blz_seg_0, 7'b0010010);
        check("def_5_seg1",  def_seg_1, 7'b1000000);
        hex = 4'd11;
        tick();
        check("blz_11_seg1", blz_seg_1, 7'b1111001);
        check("blz_11_seg0", blz_seg_0, 7'b1111001);

        // Wrap from 0 to 15 on consecutive edges.
        hex = 4'd0;
        tick();
        check("wrap_0_seg0", def_seg_0, 7'b1000000);
        hex = 4'd15;
        tick();
        check("wrap_15_seg1", def_seg_1, 7'b1111001);
        check("wrap_15_seg0", def_seg_0, 7'b0010010);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
